pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the fetch front-end (pc_reg, rom, if_id, id). It
//  arbitrates redirect requests from execute and the interrupt source, and hold
//  requests from execute and the bus, driving one jump_flag/jump_addr to pc_reg
//  and one hold_flag to pc_reg and if_id. It also runs the post-reset boot
//  sequence, post-redirect flush bubbles and a stall watchdog.
// PARAMETERS
//  BOOT_CYCLES    4      cycles held in BOOT after reset release (>=1)
//  FLUSH_CYCLES   2      bubble cycles after any redirect (>=1)
//  STALL_TIMEOUT  1024   consecutive hold-request cycles before watchdog trips
//  RESET_ADDR     32'h0  PC forced during BOOT
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   reset, asynchronous, active-high
//  ex_jump_flag_i  in   1   execute branch/jump taken
//  ex_jump_addr_i  in   32  execute redirect target
//  ex_hold_req_i   in   1   execute multi-cycle op busy
//  bus_hold_req_i  in   1   instruction/data bus busy
//  int_req_i       in   1   interrupt request, level, held until int_ack_o
//  int_addr_i      in   32  interrupt vector
//  int_ack_o       out  1   1-cycle pulse: interrupt taken this cycle
//  jump_flag_o     out  1   to pc_reg jump_flag_i
//  jump_addr_o     out  32  to pc_reg jump_addr_i
//  hold_flag_o     out  3   to pc_reg/if_id: NONE=0 PC=1 IF=2 ID=3 (defines.v)
//  stall_timeout_o out  1   sticky watchdog flag
//  state_o         out  2   debug: BOOT=0 RUN=1 FLUSH=2 STALL=3
// BEHAVIOUR
//  - Registered: state, cnt, stall_cnt, stall_timeout_o. Other outputs decode
//    state and the current inputs combinationally (0-cycle redirect latency).
//  - rst high: state=BOOT, cnt=BOOT_CYCLES-1, stall_cnt=0, timeout=0.
//    Outputs are jump_flag=1, jump_addr=RESET_ADDR, hold=ID, int_ack=0.
//  - BOOT: drive the outputs above. All requests are ignored. cnt decrements.
//    At cnt==0 go to RUN. The first RUN cycle fetches RESET_ADDR.
//  - RUN priority: ex_jump > int_req > hold requests.
//    - ex_jump: jump_flag=1, addr=ex_jump_addr_i, hold=ID.
//      -> FLUSH, cnt=FLUSH_CYCLES-1.
//    - int_req (no ex_jump): int_ack=1, jump_flag=1, addr=int_addr_i, hold=ID.
//      -> FLUSH. A losing int_req stays pending, with no ack.
//    - hold only: hold=ID if ex_hold_req_i, else PC. jump_flag=0. -> STALL.
//    - none: hold=NONE, jump_flag=0, jump_addr=0.
//  - FLUSH: hold=IF, jump_flag=0, int not accepted. cnt decrements.
//    At cnt==0 -> RUN. An ex_jump in FLUSH is accepted (jump, hold=ID) and
//    cnt reloads.
//  - STALL: hold=ID if ex_hold_req_i, else PC if bus_hold_req_i.
//    - ex_jump in STALL: redirect as in RUN -> FLUSH. It overrides any hold.
//    - both holds low: hold=NONE this cycle -> RUN. int_req is serviced next
//      cycle at the earliest.
//  - Watchdog: stall_cnt counts consecutive cycles with any hold request in
//    RUN/STALL. It clears on a cycle with no request, saturates at
//    STALL_TIMEOUT, and timeout sets on the edge where stall_cnt==STALL_TIMEOUT
//    and a request is present. timeout is sticky until rst; it only flags and
//    never changes the sequencing.
//  - jump_addr_o=0 whenever jump_flag_o=0. int_ack_o never asserts outside RUN.
//  - rst mid-operation: immediate async return to BOOT. A pending int is
//    dropped until re-seen in RUN.
// TESTING
//  1 BOOT_CYCLES=4, release rst -> 4 cycles jump=1/addr=0/hold=3, then hold=0,
//    state_o=1.
//  2 RUN, ex_jump=1 addr=0x40 for 1 cycle -> same cycle jump=1/0x40/hold=3,
//    next 2 cycles hold=2, then 0.
//  3 int_req (vec 0x100) with ex_jump 0x40 -> redirect 0x40, ack=0. After the
//    flush: ack=1 one cycle, jump to 0x100.
//  4 ex_hold 5 cycles -> hold=3 for 5 cycles, 0 after. bus_hold only -> hold=1.
//    ex_jump 0x80 mid-stall -> jump.
//  5 STALL_TIMEOUT=8, bus_hold held 12 cycles -> timeout=1 from cycle 9,
//    stays 1 after release until rst.
//  6 rst pulse mid-FLUSH with int_req high -> outputs = BOOT values at once,
//    ack=0, timeout cleared.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the fetch-front-end sequencer and its neighbours
// (execute, interrupt source, bus, pc_reg, if_id).
interface pipe_ctrl_if;
    logic        ex_jump_flag_i;
    logic [31:0] ex_jump_addr_i;
    logic        ex_hold_req_i;
    logic        bus_hold_req_i;
    logic        int_req_i;
    logic [31:0] int_addr_i;
    logic        int_ack_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic [2:0]  hold_flag_o;
    logic        stall_timeout_o;
    logic [1:0]  state_o;

    // Requester side: execute / interrupt / bus drive requests and observe the sequencer.
    modport master (
        output ex_jump_flag_i, ex_jump_addr_i, ex_hold_req_i, bus_hold_req_i,
               int_req_i, int_addr_i,
        input  int_ack_o, jump_flag_o, jump_addr_o, hold_flag_o,
               stall_timeout_o, state_o
    );

    modport slave (
        input  ex_jump_flag_i, ex_jump_addr_i, ex_hold_req_i, bus_hold_req_i,
               int_req_i, int_addr_i,
        output int_ack_o, jump_flag_o, jump_addr_o, hold_flag_o,
               stall_timeout_o, state_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Fetch front-end sequencer: boot sequence, redirect/interrupt arbitration, flush
// bubbles, hold merging and a sticky stall watchdog. Outputs decode state + inputs.
module pipe_ctrl #(
    parameter int unsigned BOOT_CYCLES   = 4,
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter logic [31:0] RESET_ADDR    = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_STALL = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        HOLD_NONE = 3'd0,
        HOLD_PC   = 3'd1,
        HOLD_IF   = 3'd2,
        HOLD_ID   = 3'd3
    } hold_t;

    localparam int unsigned CNT_MAX = (BOOT_CYCLES > FLUSH_CYCLES) ? BOOT_CYCLES : FLUSH_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned ST_W    = $clog2(STALL_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] BOOT_LOAD  = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [ST_W-1:0]  STALL_MAX  = ST_W'(STALL_TIMEOUT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [ST_W-1:0]  r_stall_cnt;
    logic             r_timeout;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_jump;
    logic [31:0]      w_addr;
    hold_t            w_hold;
    logic             w_ack;
    logic             w_any_hold;
    logic             w_wd_req;

    assign w_any_hold = bus.ex_hold_req_i | bus.bus_hold_req_i;
    assign w_wd_req   = ((r_state == ST_RUN) || (r_state == ST_STALL)) && w_any_hold;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_jump       = 1'b0;
        w_addr       = 32'h0;
        w_hold       = HOLD_NONE;
        w_ack        = 1'b0;

        unique case (r_state)
            ST_BOOT: begin
                w_jump = 1'b1;
                w_addr = RESET_ADDR;
                w_hold = HOLD_ID;
                if (r_cnt == '0) w_next_state = ST_RUN;
                else             w_next_cnt   = r_cnt - 1'b1;
            end

            ST_RUN: begin
                if (bus.ex_jump_flag_i) begin
                    w_jump       = 1'b1;
                    w_addr       = bus.ex_jump_addr_i;
                    w_hold       = HOLD_ID;
                    w_next_state = ST_FLUSH;
                    w_next_cnt   = FLUSH_LOAD;
                end else if (bus.int_req_i) begin
                    w_ack        = 1'b1;
                    w_jump       = 1'b1;
                    w_addr       = bus.int_addr_i;
                    w_hold       = HOLD_ID;
                    w_next_state = ST_FLUSH;
                    w_next_cnt   = FLUSH_LOAD;
                end else if (w_any_hold) begin
                    w_hold       = bus.ex_hold_req_i ? HOLD_ID : HOLD_PC;
                    w_next_state = ST_STALL;
                end
            end

            ST_FLUSH: begin
                // A redirect during the bubbles restarts them from the new target.
                if (bus.ex_jump_flag_i) begin
                    w_jump     = 1'b1;
                    w_addr     = bus.ex_jump_addr_i;
                    w_hold     = HOLD_ID;
                    w_next_cnt = FLUSH_LOAD;
                end else begin
                    w_hold = HOLD_IF;
                    if (r_cnt == '0) w_next_state = ST_RUN;
                    else             w_next_cnt   = r_cnt - 1'b1;
                end
            end

            ST_STALL: begin
                if (bus.ex_jump_flag_i) begin
                    w_jump       = 1'b1;
                    w_addr       = bus.ex_jump_addr_i;
                    w_hold       = HOLD_ID;
                    w_next_state = ST_FLUSH;
                    w_next_cnt   = FLUSH_LOAD;
                end else if (bus.ex_hold_req_i) begin
                    w_hold = HOLD_ID;
                end else if (bus.bus_hold_req_i) begin
                    w_hold = HOLD_PC;
                end else begin
                    w_next_state = ST_RUN;
                end
            end

            default: w_next_state = ST_BOOT;
        endcase
    end

    // NOTE: all state below updates with non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_BOOT;
            r_cnt       <= BOOT_LOAD;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;

            if (!w_wd_req)                 r_stall_cnt <= '0;
            else if (r_stall_cnt != STALL_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;

            // Sticky until reset; the watchdog only reports, it never alters sequencing.
            if (w_wd_req && (r_stall_cnt == STALL_MAX)) r_timeout <= 1'b1;
        end
    end

    assign bus.jump_flag_o     = w_jump;
    assign bus.jump_addr_o     = w_addr;
    assign bus.hold_flag_o     = w_hold;
    assign bus.int_ack_o       = w_ack;
    assign bus.stall_timeout_o = r_timeout;
    assign bus.state_o         = r_state;

endmodule
